// File: rtl/reg_arb_pkg.sv
// ============================================================================
// Module      : reg_arb_pkg
// Description : Shared types, default sizes and width helper for the shared
//               register write arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package reg_arb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    localparam int NUM_REQ_DEF  = 4;
    localparam int DATA_W_DEF   = 7;
    localparam int MAX_LOCK_DEF = 8;

    // Width of an index into n items; never less than one bit.
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/reg_write_arbiter_if.sv
// ============================================================================
// Module      : reg_write_arbiter_if
// Description : Requester-side request bundle and shared-register write port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface reg_write_arbiter_if
    import reg_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int DATA_W  = DATA_W_DEF
);
    localparam int IDX_W = idx_w(NUM_REQ);

    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        lock;
    logic [NUM_REQ*DATA_W-1:0] wdata;
    logic [NUM_REQ-1:0]        ack;
    logic                      reg_en;
    logic [DATA_W-1:0]         reg_d;
    logic [IDX_W-1:0]          grant_id;
    logic                      busy;

    modport master (
        output req, lock, wdata,
        input  ack, reg_en, reg_d, grant_id, busy
    );

    modport slave (
        input  req, lock, wdata,
        output ack, reg_en, reg_d, grant_id, busy
    );

endinterface

`default_nettype wire

// File: rtl/reg_write_arbiter_rr_pick.sv
// ============================================================================
// Module      : rr_pick
// Description : Find-first-set over req, scanning upward from ptr with wrap.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  wire logic [N-1:0]     req,
    input  wire logic [IDX_W-1:0] ptr,
    output logic                  found,
    output logic [IDX_W-1:0]      idx
);

    logic [IDX_W-1:0] cand;

    // Walk offsets from farthest to nearest so the nearest set bit wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int k = N - 1; k >= 0; k--) begin
            cand = IDX_W'((int'(ptr) + k) % N);
            if (req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/reg_write_arbiter.sv
// ============================================================================
// Module      : reg_write_arbiter
// Description : Round-robin arbiter sharing one en/d register write port among
//               NUM_REQ requesters, with a bounded back-to-back lock.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_write_arbiter
    import reg_arb_pkg::*;
#(
    parameter int NUM_REQ  = NUM_REQ_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int MAX_LOCK = MAX_LOCK_DEF
) (
    input  wire logic           clk,
    input  wire logic           reset,
    reg_write_arbiter_if.slave  bus
);

    localparam int IDX_W = idx_w(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_LOCK) + 1;
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(MAX_LOCK - 1);
    localparam logic [IDX_W-1:0] LAST_ID   = IDX_W'(NUM_REQ - 1);

    arb_state_t       state_q, state_d;
    logic [IDX_W-1:0] gid_q, gid_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;

    logic             busy;
    logic             req_gid;
    logic             hold;
    logic [IDX_W-1:0] scan_ptr;
    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;

    assign busy    = (state_q == GRANT);
    assign req_gid = bus.req[gid_q];
    assign hold    = busy && req_gid && bus.lock[gid_q] && (lock_cnt_q < LOCK_LAST);

    // Leaving a grant always restarts the scan just past the old grantee.
    always_comb begin
        scan_ptr = ptr_q;
        if (busy) begin
            scan_ptr = (gid_q == LAST_ID) ? '0 : gid_q + 1'b1;
        end
    end

    rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req   (bus.req),
        .ptr   (scan_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        state_d    = state_q;
        gid_d      = gid_q;
        ptr_d      = ptr_q;
        lock_cnt_d = lock_cnt_q;
        if (hold) begin
            lock_cnt_d = lock_cnt_q + 1'b1;
        end else begin
            ptr_d      = scan_ptr;
            lock_cnt_d = '0;
            if (pick_found) begin
                state_d = GRANT;
                gid_d   = pick_idx;
            end else begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            gid_q      <= '0;
            ptr_q      <= '0;
            lock_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            gid_q      <= gid_d;
            ptr_q      <= ptr_d;
            lock_cnt_q <= lock_cnt_d;
        end
    end

    // Outputs follow state directly so an async reset drops reg_en/ack at once.
    assign bus.busy     = busy;
    assign bus.grant_id = gid_q;
    assign bus.reg_en   = busy && req_gid;
    assign bus.reg_d    = busy ? bus.wdata[int'(gid_q) * DATA_W +: DATA_W] : '0;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_ack
        assign bus.ack[i] = busy && req_gid && (gid_q == IDX_W'(i));
    end

endmodule

`default_nettype wire

// File: tb/tb_reg_write_arbiter.sv
// ============================================================================
// Module      : tb_reg_write_arbiter
// Description : Directed vector bench for the shared register write arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_write_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 7;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    reg_write_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus ();

    reg_write_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .DATA_W   (DATA_W),
        .MAX_LOCK (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [3:0]  req;
        logic [3:0]  lock;
        logic [27:0] wdata;
        logic [3:0]  ack;
        logic        en;
        logic [6:0]  d;
        logic        busy;
        logic [1:0]  gid;
    } vec_t;

    vec_t vt [17];

    function automatic vec_t mk(input logic [3:0] req, input logic [27:0] wd,
                                input logic [3:0] ack, input logic en,
                                input logic [6:0] d, input logic busy,
                                input logic [1:0] gid);
        vec_t v;
        v.req = req; v.lock = 4'b0000; v.wdata = wd;
        v.ack = ack; v.en = en; v.d = d; v.busy = busy; v.gid = gid;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [3:0] ack, input logic en,
                             input logic [6:0] d, input logic busy, input logic [1:0] gid,
                             input logic chk_gid);
        chk({tag, ".ack"},    32'(bus.ack),    32'(ack));
        chk({tag, ".reg_en"}, 32'(bus.reg_en), 32'(en));
        chk({tag, ".reg_d"},  32'(bus.reg_d),  32'(d));
        chk({tag, ".busy"},   32'(bus.busy),   32'(busy));
        if (chk_gid) chk({tag, ".grant_id"}, 32'(bus.grant_id), 32'(gid));
    endtask

    localparam logic [27:0] W1 = {7'h11, 7'h00, 7'h00, 7'h2A};
    localparam logic [27:0] W2 = {7'h31, 7'h22, 7'h13, 7'h04};

    initial begin
        // Reset behaviour, single writes, fairness and withdrawal, in order.
        vt[0]  = mk(4'b1000, W1, 4'b0000, 0, 7'h00, 0, 2'd0);
        vt[1]  = mk(4'b1000, W1, 4'b1000, 1, 7'h11, 1, 2'd3);
        vt[2]  = mk(4'b0000, W1, 4'b0000, 0, 7'h11, 1, 2'd3);
        vt[3]  = mk(4'b0001, W1, 4'b0000, 0, 7'h00, 0, 2'd0);
        vt[4]  = mk(4'b0001, W1, 4'b0001, 1, 7'h2A, 1, 2'd0);
        vt[5]  = mk(4'b0000, W1, 4'b0000, 0, 7'h2A, 1, 2'd0);
        vt[6]  = mk(4'b0000, W1, 4'b0000, 0, 7'h00, 0, 2'd0);
        vt[7]  = mk(4'b1111, W2, 4'b0000, 0, 7'h00, 0, 2'd0);
        vt[8]  = mk(4'b1111, W2, 4'b0010, 1, 7'h13, 1, 2'd1);
        vt[9]  = mk(4'b1111, W2, 4'b0100, 1, 7'h22, 1, 2'd2);
        vt[10] = mk(4'b1111, W2, 4'b1000, 1, 7'h31, 1, 2'd3);
        vt[11] = mk(4'b1111, W2, 4'b0001, 1, 7'h04, 1, 2'd0);
        vt[12] = mk(4'b1111, W2, 4'b0010, 1, 7'h13, 1, 2'd1);
        vt[13] = mk(4'b1011, W2, 4'b0000, 0, 7'h22, 1, 2'd2);
        vt[14] = mk(4'b1000, W2, 4'b1000, 1, 7'h31, 1, 2'd3);
        vt[15] = mk(4'b0000, W2, 4'b0000, 0, 7'h31, 1, 2'd3);
        vt[16] = mk(4'b0000, W2, 4'b0000, 0, 7'h00, 0, 2'd0);

        bus.req   = 4'($urandom);
        bus.lock  = 4'($urandom);
        bus.wdata = 28'($urandom);
        #2;
        check_out("reset", 4'b0000, 0, 7'h00, 0, 2'd0, 1);
        next_cycle();
        check_out("reset_edge", 4'b0000, 0, 7'h00, 0, 2'd0, 1);
        bus.req  = 4'b0000;
        bus.lock = 4'b0000;
        reset    = 1'b0;

        for (int i = 0; i < 17; i++) begin
            bus.req   = vt[i].req;
            bus.lock  = vt[i].lock;
            bus.wdata = vt[i].wdata;
            #2;
            check_out($sformatf("vec%0d", i), vt[i].ack, vt[i].en, vt[i].d,
                      vt[i].busy, vt[i].gid, vt[i].busy);
            next_cycle();
        end

        // Lock cap: requester 0 locked with requester 1 waiting.
        bus.req  = 4'b0011;
        bus.lock = 4'b0001;
        #2;
        chk("lock.idle_busy", 32'(bus.busy), 32'd0);
        next_cycle();
        for (int n = 0; n < 8; n++) begin
            chk($sformatf("lock.hold%0d.ack", n), 32'(bus.ack), 32'(4'b0001));
            next_cycle();
        end
        chk("lock.cap.ack", 32'(bus.ack), 32'(4'b0010));
        chk("lock.cap.gid", 32'(bus.grant_id), 32'd1);
        next_cycle();

        // Locked requester alone keeps winning across the cap.
        bus.req  = 4'b0001;
        bus.lock = 4'b0001;
        for (int n = 0; n < 12; n++) begin
            chk($sformatf("lock.alone%0d.ack", n), 32'(bus.ack), 32'(4'b0001));
            next_cycle();
        end
        bus.req  = 4'b0000;
        bus.lock = 4'b0000;
        #2;
        check_out("lock.drop", 4'b0000, 0, 7'h04, 1, 2'd0, 1);
        next_cycle();

        // Asynchronous reset in the middle of a committing grant.
        bus.req = 4'b0100;
        #2;
        chk("rst.idle_busy", 32'(bus.busy), 32'd0);
        next_cycle();
        check_out("rst.grant", 4'b0100, 1, 7'h22, 1, 2'd2, 1);
        #1;
        reset = 1'b1;
        #1;
        check_out("rst.async", 4'b0000, 0, 7'h00, 0, 2'd0, 1);
        next_cycle();
        chk("rst.held_busy", 32'(bus.busy), 32'd0);
        reset   = 1'b0;
        bus.req = 4'b0110;
        #2;
        chk("rst.post_idle_busy", 32'(bus.busy), 32'd0);
        next_cycle();
        check_out("rst.post_grant", 4'b0010, 1, 7'h13, 1, 2'd1, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
